async_reset_shift_reg: RTL and testbench

ASYNC_RESET_SHIFT_REG -- requirements
Module: async_reset_shift_reg

---
 rtl/async_reset_shift_reg_pkg.sv | 14 +
 rtl/async_reset_reg_stage.sv | 21 ++
 rtl/async_reset_shift_reg.sv | 82 ++++++++
 tb/tb_async_reset_shift_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/async_reset_shift_reg_pkg.sv
// Shared definitions for async_reset_shift_reg: fill-counter sizing and valid FSM encoding.
package async_reset_shift_reg_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } fill_state_e;

  // Bits needed to count 0..depth inclusive.
  function automatic int unsigned fill_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/async_reset_reg_stage.sv
// One WIDTH-bit storage stage with load enable and asynchronous active-low reset to INIT.
module async_reset_reg_stage #(
  parameter int unsigned      WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/async_reset_shift_reg.sv
// DEPTH-stage shift register with enable, synchronous flush to INIT and a fill-tracking valid flag.
module async_reset_shift_reg
  import async_reset_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  localparam int unsigned CNT_W = fill_cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic             load;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  fill_state_e      state, state_nxt;

  // A flush reloads every stage, so stages load on either request.
  assign load = en | flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (i == 0) begin : g_head
      assign stage_d = flush ? INIT : d;
    end else begin : g_body
      assign stage_d = flush ? INIT : stage_q[i-1];
    end

    async_reset_reg_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (load),
      .d     (stage_d),
      .q     (stage_q[i])
    );
  end

  // Fill counter and valid state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= FILLING;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // Counter saturates at DEPTH; FULL is left only through flush or reset.
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    if (flush) begin
      cnt_nxt   = '0;
      state_nxt = FILLING;
    end else if (en) begin
      if (cnt != CNT_FULL) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      if (cnt_nxt == CNT_FULL) begin
        state_nxt = FULL;
      end
    end
  end

  // Outputs gated by rst_n so reset reads correctly even without event-driven async reset.
  assign q     = rst_n ? stage_q[DEPTH-1] : INIT;
  assign valid = rst_n & (state == FULL);

endmodule

// File: tb/tb_async_reset_shift_reg.sv
// Directed bench for async_reset_shift_reg: DEPTH=3 main instance plus a DEPTH=1 instance.
module tb_async_reset_shift_reg;

  localparam logic [7:0] INIT = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic [7:0] q3, q1;
  logic       valid3, valid1;

  int errors = 0;
  int checks = 0;

  async_reset_shift_reg #(.WIDTH(8), .DEPTH(3), .INIT(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .flush (flush),
    .d     (d),
    .q     (q3),
    .valid (valid3)
  );

  async_reset_shift_reg #(.WIDTH(8), .DEPTH(1), .INIT(INIT)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .flush (flush),
    .d     (d),
    .q     (q1),
    .valid (valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and leave all inputs idle.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    en = 1'b0; flush = 1'b0; d = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; d = 8'hFF;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++;
      if (q3 !== INIT) begin
        $display("FAIL reset_q cycle %0d: got %h want %h", i, q3, INIT); errors++;
      end
      checks++;
      if (valid3 !== 1'b0) begin
        $display("FAIL reset_valid cycle %0d: got %b want 0", i, valid3); errors++;
      end
    end
    checks++;
    if (q1 !== INIT || valid1 !== 1'b0) begin
      $display("FAIL reset_depth1: got q=%h valid=%b want q=%h valid=0", q1, valid1, INIT); errors++;
    end
    en = 1'b0; d = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] din   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] exp_q [4] = '{8'hA5, 8'hA5, 8'h01, 8'h02};
    logic       exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; d = din[i];
      step();
      checks++;
      if (q3 !== exp_q[i] || valid3 !== exp_v[i]) begin
        $display("FAIL fill edge %0d: got q=%h valid=%b want q=%h valid=%b",
                 i + 1, q3, valid3, exp_q[i], exp_v[i]); errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_hold();
    en = 1'b0; d = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q3 !== 8'h02 || valid3 !== 1'b1) begin
        $display("FAIL hold edge %0d: got q=%h valid=%b want q=02 valid=1", i + 1, q3, valid3);
        errors++;
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic       en_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] din    [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp_q  [5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h11};
    logic       exp_v  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      en = en_pat[i]; d = din[i];
      step();
      checks++;
      if (q3 !== exp_q[i] || valid3 !== exp_v[i]) begin
        $display("FAIL gaps edge %0d: got q=%h valid=%b want q=%h valid=%b",
                 i + 1, q3, valid3, exp_q[i], exp_v[i]); errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] exp_q [5] = '{8'hA5, 8'hA5, 8'h77, 8'h77, 8'h77};
    logic       exp_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    flush = 1'b1; en = 1'b1; d = 8'h77;
    step();
    flush = 1'b0;
    checks++;
    if (q3 !== INIT || valid3 !== 1'b0) begin
      $display("FAIL flush_edge: got q=%h valid=%b want q=a5 valid=0", q3, valid3); errors++;
    end
    // Extra enabled edges past DEPTH check saturation of the fill count.
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; d = 8'h77;
      step();
      checks++;
      if (q3 !== exp_q[i] || valid3 !== exp_v[i]) begin
        $display("FAIL post_flush edge %0d: got q=%h valid=%b want q=%h valid=%b",
                 i + 1, q3, valid3, exp_q[i], exp_v[i]); errors++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q3 !== INIT || valid3 !== 1'b0) begin
      $display("FAIL async_reset_now: got q=%h valid=%b want q=a5 valid=0", q3, valid3); errors++;
    end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (q3 !== INIT || valid3 !== 1'b0) begin
      $display("FAIL async_reset_release: got q=%h valid=%b want q=a5 valid=0", q3, valid3);
      errors++;
    end
    en = 1'b1; d = 8'h99;
    step();
    checks++;
    if (q3 !== INIT || valid3 !== 1'b0) begin
      $display("FAIL async_reset_first_edge: got q=%h valid=%b want q=a5 valid=0", q3, valid3);
      errors++;
    end
    en = 1'b0;
  endtask

  task automatic test_depth1();
    pulse_reset();
    en = 1'b1; d = 8'h5A;
    step();
    checks++;
    if (q1 !== 8'h5A || valid1 !== 1'b1) begin
      $display("FAIL depth1_first: got q=%h valid=%b want q=5a valid=1", q1, valid1); errors++;
    end
    en = 1'b0; d = 8'h00;
    step();
    checks++;
    if (q1 !== 8'h5A || valid1 !== 1'b1) begin
      $display("FAIL depth1_hold: got q=%h valid=%b want q=5a valid=1", q1, valid1); errors++;
    end
    en = 1'b1; d = 8'hC3;
    step();
    checks++;
    if (q1 !== 8'hC3 || valid1 !== 1'b1) begin
      $display("FAIL depth1_next: got q=%h valid=%b want q=c3 valid=1", q1, valid1); errors++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0; en = 1'b0;
    checks++;
    if (q1 !== INIT || valid1 !== 1'b0) begin
      $display("FAIL depth1_flush: got q=%h valid=%b want q=a5 valid=0", q1, valid1); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_enable_gaps();
    test_flush();
    test_async_reset();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
